// File: rtl/regs_stream_ctrl.sv
// Register-file stream initiator: LOAD writes a block of registers from a byte stream,
// DUMP streams a block out. It also owns write-port hold, because the file writes every clock.
module regs_stream_ctrl #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [3:0]   cmd_base,
    input  logic [4:0]   cmd_count,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic         out_last,
    output logic [3:0]   rf_waddr,
    output logic [n-1:0] rf_wdata,
    input  logic [n-1:0] rf_rdata1,
    output logic [3:0]   rf_raddr2,
    input  logic [n-1:0] rf_rdata2,
    output logic         done,
    output logic         err,
    output logic [1:0]   dbg_state
);

    // Streams use valid/ready: a beat transfers on a rising edge where both are high;
    // the source keeps its data stable while valid is high and ready is low.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;

    state_t       state_q, state_d;
    logic [3:0]   ptr_q, ptr_d;
    logic [4:0]   remaining_q, remaining_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q, out_last_d;
    logic [n-1:0] out_data_q, out_data_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         cmd_legal;

    assign cmd_legal = ((cmd_op == OP_LOAD) || (cmd_op == OP_DUMP)) &&
                       (cmd_count != 5'd0) && (cmd_count <= 5'd16);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_legal) begin
                        state_d     = (cmd_op == OP_LOAD) ? ST_LOAD : ST_DUMP;
                        ptr_d       = cmd_base;
                        remaining_d = cmd_count;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ptr_d       = ptr_q + 4'd1;
                    remaining_d = remaining_q - 5'd1;
                    if (remaining_q == 5'd1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DUMP: begin
                // The last beat's handshake ends the command; otherwise refill the output
                // register whenever it is empty or being drained this cycle.
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if ((!out_valid_q || out_ready) && (remaining_q != 5'd0)) begin
                    out_data_d  = rf_rdata2;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == 5'd1);
                    ptr_d       = ptr_q + 4'd1;
                    remaining_d = remaining_q - 5'd1;
                end else if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 4'd0;
            remaining_q <= 5'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Write port rewrites the addressed register with its own value except on a load beat.
    assign rf_waddr  = ptr_q;
    assign rf_wdata  = ((state_q == ST_LOAD) && in_valid) ? in_data : rf_rdata1;
    assign rf_raddr2 = ptr_q;

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regs_stream_ctrl.sv
// Directed bench for regs_stream_ctrl with a behavioural 16x8 register file
// that commits rf_wdata at rf_waddr on every rising edge.
module tb_regs_stream_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_base;
  logic [4:0] cmd_count;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] rf_rdata1;
  logic [3:0] rf_raddr2;
  logic [7:0] rf_rdata2;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;

  regs_stream_ctrl #(.n(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1),
    .rf_raddr2(rf_raddr2), .rf_rdata2(rf_rdata2),
    .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / register file ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rf [16];
  assign rf_rdata1 = rf[rf_waddr];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) rf[rf_waddr] <= rf_wdata;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [7:0] exp_rf [16];
  logic [7:0] load_data [16];
  logic [7:0] exp_q [$];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] base, input logic [4:0] count);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_count = count;
    @(negedge clk);
    check("cmd_ready_at_offer", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic compare_rf(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_rf%0d", tag, i), rf[i], exp_rf[i]);
  endtask

  task automatic do_load(input logic [3:0] base, input int count);
    int d0;
    send_cmd(2'b01, base, count[4:0]);
    check("load_in_ready", in_ready, 1'b1);
    d0 = done_cnt;
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_data  = load_data[i];
      exp_rf[(int'(base) + i) % 16] = load_data[i];
      tick();
    end
    in_valid = 1'b0;
    check("load_done_at_k", done, 1'b1);
    check("load_cmd_ready_with_done", cmd_ready, 1'b1);
    tick();
    check("load_done_once", done_cnt - d0, 1);
  endtask

  task automatic do_dump(input logic [3:0] base, input int count, input logic [7:0] pat, input int pat_len);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       exp_last;
    logic [7:0] exp_data;
    int         first_cyc;
    int         finished;
    exp_q.delete();
    for (int i = 0; i < count; i++) exp_q.push_back(exp_rf[(int'(base) + i) % 16]);
    send_cmd(2'b10, base, count[4:0]);
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    first_cyc  = -1;
    finished   = 0;
    for (int cyc = 0; cyc < 60 && finished == 0; cyc++) begin
      out_ready = (cyc < pat_len) ? pat[cyc] : 1'b1;
      @(negedge clk);
      if (prev_stall) check("dump_stable", out_data, prev_data);
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("dump_extra_beat", 1'b1, 1'b0);
          exp_data = 8'h00;
        end else begin
          exp_data = exp_q.pop_front();
        end
        exp_last = (exp_q.size() == 0);
        check("dump_data", out_data, exp_data);
        check("dump_last", out_last, exp_last);
        if (exp_last) begin
          tick();
          check("dump_done", done, 1'b1);
          check("dump_cmd_ready_with_done", cmd_ready, 1'b1);
          if (pat_len == 0) check("dump_cycles_full_rate", cyc, count);
          finished = 1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (finished == 0) tick();
    end
    if (finished == 0) check("dump_timeout", 1'b0, 1'b1);
    check("dump_first_valid_cycle", first_cyc, 1);
    check("dump_beats_left", exp_q.size(), 0);
    out_ready = 1'b0;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  int d0;
  int e0;
  logic [1:0] bad_op [4];
  logic [4:0] bad_cnt [4];

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf[i] = 8'h00;
      exp_rf[i] = 8'h00;
    end
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_base = 4'd0; cmd_count = 5'd0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_waddr", rf_waddr, 4'd0);
    reset = 1'b0;
    tick();

    // preload all 16 registers (also exercises count 16)
    for (int i = 0; i < 16; i++) load_data[i] = 8'h10 + 8'(i * 3);
    do_load(4'd0, 16);
    compare_rf("preload");

    // LOAD base 14 count 4 with wrap
    load_data[0] = 8'hA1; load_data[1] = 8'hA2; load_data[2] = 8'hA3; load_data[3] = 8'hA4;
    do_load(4'd14, 4);
    check("wrap_r14", rf[14], 8'hA1);
    check("wrap_r1", rf[1], 8'hA4);
    compare_rf("wrap_load");

    // DUMP base 14 count 4, full rate
    do_dump(4'd14, 4, 8'h00, 0);

    // DUMP count 3 with ready 1-0-0-1-1
    do_dump(4'd5, 3, 8'b0001_1001, 5);

    // illegal commands
    bad_op[0] = 2'b00; bad_cnt[0] = 5'd4;
    bad_op[1] = 2'b11; bad_cnt[1] = 5'd4;
    bad_op[2] = 2'b01; bad_cnt[2] = 5'd0;
    bad_op[3] = 2'b10; bad_cnt[3] = 5'd17;
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      send_cmd(bad_op[i], 4'd3, bad_cnt[i]);
      check($sformatf("bad%0d_err", i), err, 1'b1);
      check($sformatf("bad%0d_cmd_ready", i), cmd_ready, 1'b1);
      check($sformatf("bad%0d_state", i), dbg_state, 2'd0);
      tick();
      check($sformatf("bad%0d_err_pulse", i), err, 1'b0);
      check($sformatf("bad%0d_no_done", i), done_cnt - d0, 0);
    end
    compare_rf("after_bad");

    // LOAD count 8 aborted by reset after 3 beats
    for (int i = 0; i < 8; i++) load_data[i] = 8'hB0 + 8'(i);
    d0 = done_cnt;
    send_cmd(2'b01, 4'd0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = load_data[i];
      exp_rf[i] = load_data[i];
      tick();
    end
    in_data = 8'hEE;
    reset = 1'b1;
    #1;
    check("abort_cmd_ready", cmd_ready, 1'b1);
    check("abort_in_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check("abort_no_done", done_cnt - d0, 0);
    compare_rf("abort_load");
    do_dump(4'd0, 4, 8'h00, 0);

    // reset during a stalled DUMP drops out_valid at once
    d0 = done_cnt;
    out_ready = 1'b0;
    send_cmd(2'b10, 4'd8, 5'd2);
    tick();
    check("dump_stall_valid", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("dump_abort_valid", out_valid, 1'b0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    check("dump_abort_no_done", done_cnt - d0, 0);

    // hold path over 100 idle cycles
    e0 = err_cnt;
    repeat (100) tick();
    compare_rf("idle100");
    check("idle_no_err", err_cnt - e0, 0);
    check("done_err_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
